// File: rtl/stream_demux_reg.sv
// Registered 1:N word-stream demultiplexer with per-channel one-entry holding registers,
// unicast/broadcast routing, a sticky out-of-range select flag and an accepted-word counter.
module stream_demux_reg #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    input  logic [WIDTH-1:0]          in_data,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      sel_err,
    output logic [CNT_W-1:0]          xfer_count
);

    logic [CHANNELS-1:0] free;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] load;
    logic                sel_ok;
    logic                sel_free;
    logic                accept;

    // A draining register counts as free, so a channel sustains one word per cycle.
    assign free   = ~out_valid | out_ready;
    assign sel_ok = {1'b0, in_sel} < (SEL_W + 1)'(CHANNELS);

    always_comb begin
        hit      = '0;
        sel_free = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            hit[k] = (in_sel == SEL_W'(k));
            if (hit[k]) begin
                sel_free = free[k];
            end
        end
    end

    // Out-of-range unicast words are always taken so the source never stalls on them.
    assign in_ready = in_bcast ? (&free) : (sel_ok ? sel_free : 1'b1);
    assign accept   = in_valid & in_ready;
    assign load     = {CHANNELS{accept}} & (hit | {CHANNELS{in_bcast}});

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= '0;
            sel_err    <= 1'b0;
            xfer_count <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k]) begin
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                    out_valid[k]               <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (accept) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
            if (accept && !in_bcast && !sel_ok) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_reg.sv
// Bench for stream_demux_reg: an 8-channel instance and a 6-channel/4-bit-counter instance,
// each checked every cycle against a behavioural model, plus hand-computed expectations.
module tb_stream_demux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         a_valid, a_bcast, a_ready, a_err;
    logic [2:0]   a_sel;
    logic [15:0]  a_data, a_cnt;
    logic [7:0]   a_ordy, a_ovalid;
    logic [127:0] a_odata;

    logic         b_valid, b_bcast, b_ready, b_err;
    logic [2:0]   b_sel;
    logic [15:0]  b_data;
    logic [3:0]   b_cnt;
    logic [5:0]   b_ordy, b_ovalid;
    logic [95:0]  b_odata;

    stream_demux_reg #(.WIDTH(16), .CHANNELS(8), .SEL_W(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_sel(a_sel),
        .in_bcast(a_bcast), .in_data(a_data), .out_data(a_odata), .out_valid(a_ovalid),
        .out_ready(a_ordy), .sel_err(a_err), .xfer_count(a_cnt)
    );

    stream_demux_reg #(.WIDTH(16), .CHANNELS(6), .SEL_W(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_sel(b_sel),
        .in_bcast(b_bcast), .in_data(b_data), .out_data(b_odata), .out_valid(b_ovalid),
        .out_ready(b_ordy), .sel_err(b_err), .xfer_count(b_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Model state, index 0 = 8-channel instance, 1 = 6-channel instance.
    logic [15:0] m_data  [2][16];
    bit          m_valid [2][16];
    bit          m_err   [2];
    int          m_cnt   [2];

    function automatic bit m_ready(input int id, input int nch, input bit bcast,
                                   input int sel, input logic [15:0] ordy);
        bit r;
        if (bcast) begin
            r = 1'b1;
            for (int k = 0; k < nch; k++)
                if (m_valid[id][k] && !ordy[k]) r = 1'b0;
        end else if (sel >= nch) begin
            r = 1'b1;
        end else begin
            r = !m_valid[id][sel] || ordy[sel];
        end
        return r;
    endfunction

    task automatic m_step(input int id, input int nch, input int cntw, input bit valid,
                          input bit bcast, input int sel, input logic [15:0] data,
                          input logic [15:0] ordy);
        bit acc;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_data[id][k]  = '0;
                m_valid[id][k] = 1'b0;
            end
            m_err[id] = 1'b0;
            m_cnt[id] = 0;
        end else begin
            acc = valid && m_ready(id, nch, bcast, sel, ordy);
            for (int k = 0; k < nch; k++) begin
                if (acc && (bcast || sel == k)) begin
                    m_data[id][k]  = data;
                    m_valid[id][k] = 1'b1;
                end else if (ordy[k]) begin
                    m_valid[id][k] = 1'b0;
                end
            end
            if (acc) m_cnt[id] = (m_cnt[id] + 1) % (1 << cntw);
            if (acc && !bcast && sel >= nch) m_err[id] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        m_step(0, 8, 16, a_valid, a_bcast, int'(a_sel), a_data, {8'h00, a_ordy});
        m_step(1, 6, 4, b_valid, b_bcast, int'(b_sel), b_data, {10'h000, b_ordy});
    end

    always @(negedge clk) begin
        logic [127:0] e_data;
        logic [15:0]  e_valid;
        if (cmp_en) begin
            e_data = '0; e_valid = '0;
            for (int k = 0; k < 8; k++) begin
                e_data[k*16 +: 16] = m_data[0][k];
                e_valid[k]         = m_valid[0][k];
            end
            chk("a_out_data", a_odata, e_data);
            chk("a_out_valid", a_ovalid, e_valid);
            chk("a_in_ready", a_ready, m_ready(0, 8, a_bcast, int'(a_sel), {8'h00, a_ordy}));
            chk("a_sel_err", a_err, m_err[0]);
            chk("a_xfer_count", a_cnt, m_cnt[0]);
            e_data = '0; e_valid = '0;
            for (int k = 0; k < 6; k++) begin
                e_data[k*16 +: 16] = m_data[1][k];
                e_valid[k]         = m_valid[1][k];
            end
            chk("b_out_data", b_odata, e_data);
            chk("b_out_valid", b_ovalid, e_valid);
            chk("b_in_ready", b_ready, m_ready(1, 6, b_bcast, int'(b_sel), {10'h000, b_ordy}));
            chk("b_sel_err", b_err, m_err[1]);
            chk("b_xfer_count", b_cnt, m_cnt[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 0; a_bcast = 0; a_sel = 0; a_data = 0; a_ordy = 0;
        b_valid = 0; b_bcast = 0; b_sel = 0; b_data = 0; b_ordy = 0;
        step(); step();
        cmp_en = 1'b1;

        // reset with a pending word, then first edge out of reset accepts
        a_valid = 1; a_sel = 3'd2; a_data = 16'h1234;
        step(); step();
        #1;
        chk("lit_rst_out_valid", a_ovalid, 8'h00);
        chk("lit_rst_xfer_count", a_cnt, 0);
        chk("lit_rst_sel_err", a_err, 0);
        rst = 1'b0;
        step();
        a_valid = 0;
        #1;
        chk("lit_post_rst_valid", a_ovalid, 8'h04);
        chk("lit_post_rst_data2", a_odata[47:32], 16'h1234);
        chk("lit_post_rst_count", a_cnt, 1);

        // unicast and back-pressure
        pulse_rst();
        a_sel = 3'd5; a_data = 16'hA5C3; a_ordy = 8'h00; a_valid = 1;
        step();
        a_data = 16'h1111;
        #1;
        chk("lit_uni_valid", a_ovalid, 8'h20);
        chk("lit_uni_data5", a_odata[95:80], 16'hA5C3);
        chk("lit_uni_count", a_cnt, 1);
        chk("lit_uni_blocked", a_ready, 0);
        step();
        #1;
        chk("lit_uni_still_blocked", a_ready, 0);
        chk("lit_uni_hold_data", a_odata[95:80], 16'hA5C3);
        a_ordy = 8'h20;
        #1;
        chk("lit_uni_unblocked", a_ready, 1);
        step();
        a_valid = 0;
        #1;
        chk("lit_uni_replace", a_odata[95:80], 16'h1111);
        chk("lit_uni_count2", a_cnt, 2);
        step();
        a_ordy = 8'h00;
        #1;
        chk("lit_uni_drained", a_ovalid, 8'h00);
        chk("lit_uni_data_kept", a_odata[95:80], 16'h1111);

        // back-to-back streaming on channel 0
        pulse_rst();
        a_sel = 3'd0; a_ordy = 8'h01; a_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            a_data = 16'(i);
            #1;
            chk("lit_stream_ready", a_ready, 1);
            step();
            #1;
            chk("lit_stream_data0", a_odata[15:0], i);
            chk("lit_stream_valid", a_ovalid, 8'h01);
        end
        a_valid = 0;
        chk("lit_stream_count", a_cnt, 4);
        step();
        #1;
        chk("lit_stream_empty", a_ovalid, 8'h00);

        // broadcast blocked by one full channel
        pulse_rst();
        a_sel = 3'd3; a_data = 16'h3333; a_ordy = 8'h00; a_valid = 1;
        step();
        a_bcast = 1; a_data = 16'h0F0F;
        #1;
        chk("lit_bc_blocked", a_ready, 0);
        chk("lit_bc_ch3_full", a_ovalid, 8'h08);
        step();
        #1;
        chk("lit_bc_still_blocked", a_ready, 0);
        a_ordy = 8'h08;
        #1;
        chk("lit_bc_unblocked", a_ready, 1);
        step();
        a_valid = 0; a_bcast = 0;
        #1;
        chk("lit_bc_all_valid", a_ovalid, 8'hFF);
        chk("lit_bc_all_data", a_odata, {8{16'h0F0F}});
        chk("lit_bc_count", a_cnt, 2);
        a_ordy = 8'hFF;
        step();
        a_ordy = 8'h00;
        #1;
        chk("lit_bc_drained", a_ovalid, 8'h00);

        // invalid select on the 6-channel instance
        pulse_rst();
        b_sel = 3'd7; b_valid = 1; b_ordy = 6'h00;
        #1;
        chk("lit_bad_sel_ready", b_ready, 1);
        step();
        b_valid = 0;
        #1;
        chk("lit_bad_sel_no_load", b_ovalid, 6'h00);
        chk("lit_bad_sel_err", b_err, 1);
        chk("lit_bad_sel_count", b_cnt, 1);
        step(); step();
        #1;
        chk("lit_bad_sel_sticky", b_err, 1);
        b_sel = 3'd2; b_data = 16'hBEEF; b_valid = 1;
        step();
        b_valid = 0;
        #1;
        chk("lit_good_after_bad", b_ovalid, 6'h04);
        chk("lit_good_data2", b_odata[47:32], 16'hBEEF);
        chk("lit_err_still_set", b_err, 1);
        pulse_rst();
        #1;
        chk("lit_err_cleared", b_err, 0);
        chk("lit_b_rst_valid", b_ovalid, 6'h00);

        // 4-bit counter wrap, then reset mid-stream
        b_sel = 3'd1; b_ordy = 6'h3F; b_valid = 1;
        for (int i = 1; i <= 17; i++) begin
            b_data = 16'(i);
            step();
            #1;
            chk("lit_wrap_count", b_cnt, i % 16);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("lit_midrst_count", b_cnt, 0);
        chk("lit_midrst_valid", b_ovalid, 6'h00);
        step();
        b_valid = 0;
        #1;
        chk("lit_after_midrst_count", b_cnt, 1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_demux_reg.md
Name: stream_demux_reg

Overview:
- Registered, parametrised 1:N demultiplexer for word streams, e.g. routing memory data-out words to N consumers.
- Each output channel has a one-entry holding register with valid/ready flow control.
- Supports unicast to the channel chosen by `in_sel`, or broadcast to all channels.
- Flags out-of-range selects and counts accepted words.

Parameters:
- WIDTH, 16, data word width in bits.
- CHANNELS, 8, number of output channels (2..16).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= CHANNELS.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_sel  input  SEL_W  destination channel index (ignored when in_bcast=1).
- in_bcast  input  1  deliver word to all channels.
- in_data  input  WIDTH  input word.
- out_data  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  CHANNELS  per-channel holding register full.
- out_ready  input  CHANNELS  per-channel consumer accepts this cycle.
- sel_err  output  1  sticky; set on an accepted-attempt with in_sel >= CHANNELS.
- xfer_count  output  CNT_W  number of input words accepted, wrapping.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, sel_err=0, xfer_count=0. Reset overrides any simultaneous handshake. A word pending mid-transfer is discarded.
- Per-channel free condition: free[k] = !out_valid[k] | out_ready[k]. A draining register can accept a new word in the same cycle.
- in_ready (combinational, no dependence on in_valid):
  - unicast, in_sel < CHANNELS: in_ready = free[in_sel].
  - broadcast: in_ready = AND of free[k] over all k.
  - unicast, in_sel >= CHANNELS: in_ready = 1. The word is consumed and dropped.
- Accept = in_valid & in_ready.
- Unicast accept, valid select: at the next edge, out_data[in_sel] <= in_data and out_valid[in_sel] <= 1. Latency is 1 cycle from accept to out_valid.
- Broadcast accept: every channel loads in_data and sets out_valid at the same edge.
- Drain: if out_valid[k] & out_ready[k] and channel k is not loaded this cycle, out_valid[k] <= 0. out_data[k] holds its last value; it is not cleared.
- Load and drain in the same cycle on one channel: the new word replaces the old one and out_valid stays 1. Full throughput is 1 word/cycle per channel.
- Non-targeted channels are unaffected by an accept.
- Invalid select accept: no channel is loaded, sel_err <= 1 (sticky until rst), and xfer_count still increments.
- xfer_count increments by 1 on every accept (unicast, broadcast or dropped), modulo 2**CNT_W. It wraps from all-ones to 0.
- Flow-control rules:
  - in_data/in_sel/in_bcast need only be stable in cycles where in_valid=1.
  - Once a channel has out_valid=1, its out_data stays stable until out_ready is seen.
  - The block never deasserts out_valid without a handshake, except on reset.
- No combinational path from in_valid/in_data to any out_* signal. There is a combinational path from out_ready to in_ready.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_sel=2 -> out_valid=8'h00, xfer_count=0, sel_err=0; first edge after rst=0 accepts normally.
- Unicast: in_sel=5, in_data=16'hA5C3, out_ready=0 -> next cycle out_valid=8'h20 and out_data[5]=16'hA5C3. Second word to sel 5 sees in_ready=0 until out_ready[5]=1. xfer_count=1 after the first word.
- Streaming: 4 back-to-back words 1,2,3,4 to sel 0 with out_ready[0]=1 -> in_ready stays 1, channel 0 presents 1,2,3,4 on consecutive cycles, xfer_count=4.
- Broadcast: out_valid[3]=1 with out_ready[3]=0, in_bcast=1, data 16'h0F0F -> in_ready=0. Raise out_ready[3] -> accept, all 8 channels show 16'h0F0F next cycle.
- Invalid select: CHANNELS=6, SEL_W=3, in_sel=7 -> in_ready=1, no out_valid change, sel_err=1 and stays 1 until rst. xfer_count increments.
- Counter wrap: CNT_W=4, 17 accepts -> xfer_count reads 15 then 0 then 1. Reset mid-stream clears it to 0.
